pio_write_arbiter: RTL and testbench
====================================

PIO_WRITE_ARBITER -- requirements
Module: pio_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 9, PIO output-register width.
REQ-003 SHALL have parameter RESET_VAL, default 4, PIO register reset value mirrored in the shadow register.
REQ-004 SHALL have clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have req  in  NUM_REQ  per-requester write request, held high until that requester's ack.
REQ-007 SHALL have req_data  in  NUM_REQ*DATA_W  value per requester; slice i is bits [i*DATA_W +: DATA_W], stable while req[i] is high.
REQ-008 SHALL have ack  out  NUM_REQ  one-cycle completion pulse per requester.
REQ-009 SHALL have avm_address  out  2  Avalon-MM address, always 0.
REQ-010 SHALL have avm_chipselect  out  1  Avalon-MM chip select.
REQ-011 SHALL have avm_write_n  out  1  Avalon-MM active-low write.
REQ-012 SHALL have avm_writedata  out  32  write data: {zeros, granted value}.
REQ-013 SHALL have avm_readdata  in  32  PIO read data, combinational and zero-wait.
REQ-014 SHALL have busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have shadow  out  DATA_W  last value written to the PIO.
REQ-016 SHALL have err  out  1  sticky readback-mismatch flag.

Function
REQ-017 SHALL implement FSM IDLE -> WRITE -> [READ] -> DONE -> IDLE.
- READ exists only with the Configuration macro.
REQ-018 In IDLE with any req bit high, SHALL grant exactly one requester by round-robin and latch its index and req_data slice.
- Grant search starts at pointer ptr; ptr resets to 0.
- After a grant to i, ptr becomes (i+1) mod NUM_REQ.
REQ-019 In IDLE with no request, SHALL stay in IDLE with chipselect=0 and write_n=1.
REQ-020 WRITE SHALL last exactly one cycle with chipselect=1, write_n=0, address=0, writedata={(32-DATA_W)'b0, latched data}.
- In that cycle shadow SHALL load the latched data.
REQ-021 READ SHALL last one cycle with chipselect=1, write_n=1, address=0.
- It SHALL compare avm_readdata[DATA_W-1:0] with the latched data and set err on mismatch.
REQ-022 In DONE, ack[granted] SHALL be high for exactly that one cycle.
- All other ack bits stay 0.
- req SHALL be ignored in DONE.
REQ-023 Latency from a req sampled in IDLE to ack SHALL be 2 cycles without the macro and 3 cycles with it.
- Back-to-back throughput SHALL be one write per 3 (4) cycles.
REQ-024 Simultaneous requests SHALL be serviced one per transaction in round-robin order; no requester SHALL wait more than NUM_REQ-1 transactions.
REQ-025 A req dropped mid-transaction SHALL NOT abort the transaction; ack is still issued.
REQ-026 Bus outputs SHALL be driven from registered state only, with no combinational path from req to the avm_* outputs.

Reset
REQ-027 While reset is high, SHALL return to IDLE regardless of the current state, including mid-WRITE.
- On reset: ptr=0, ack=0, chipselect=0, write_n=1, address=0, writedata=0, busy=0, shadow=RESET_VAL, err=0.
REQ-028 err SHALL clear only on reset.

Configuration
REQ-029 Macro PIO_WRITE_ARBITER_READBACK_EN defined: READ state and err logic compiled in.
REQ-030 Macro absent: WRITE goes directly to DONE, err is tied to 0, and avm_readdata is unused.

Structure
REQ-031 Package pio_arb_pkg SHALL hold the FSM state enum, PIO_ADDR=2'd0, and AVM_DATA_W=32.
REQ-032 Round-robin grant logic SHALL be a sub-module rr_arbiter with inputs req and ptr and a one-hot grant output.

Verification
REQ-033 reset then idle: shadow=4, err=0, chipselect=0, write_n=1, ack=0.
REQ-034 req[2]=1, data 9'h1A5: one write cycle with writedata=32'h1A5, ack[2] 2 cycles after the request (3 with macro), shadow=9'h1A5.
REQ-035 req=4'b1111 held, each dropped after its ack: grant order 0,1,2,3, four writes, no gaps beyond the FSM.
REQ-036 macro on, readdata forced to 0 while writing 9'h0FF: err=1 and stays set until reset.
REQ-037 reset asserted in the WRITE cycle: next cycle IDLE, no ack, ptr=0, shadow=4.

Source files
------------

// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO write arbiter.
// Optional readback stage is enabled by defining PIO_WRITE_ARBITER_READBACK_EN.
package pio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] PIO_ADDR   = 2'd0;
    localparam int         AVM_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: lowest requester at or above ptr wins,
// otherwise wrap around to the lowest requester overall.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] masked_req;

    // Bits at or above the pointer are searched first.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
        assign upper_mask[gi] = (PTR_W'(gi) >= ptr);
    end

    assign masked_req = req & upper_mask;

    // Isolate the lowest set bit of whichever vector holds the winner.
    always_comb begin
        if (masked_req != '0) begin
            grant = masked_req & (~masked_req + NUM_REQ'(1));
        end else begin
            grant = req & (~req + NUM_REQ'(1));
        end
    end

endmodule

// File: rtl/pio_write_arbiter.sv
// Arbitrates single-value writes from several requesters onto one Avalon-MM PIO
// register, keeps a shadow copy of the last written value, and acknowledges the
// winner. Defining PIO_WRITE_ARBITER_READBACK_EN adds a readback-verify cycle
// that sets a sticky err flag on mismatch.
module pio_write_arbiter
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 9,
    parameter int RESET_VAL = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [1:0]                avm_address,
    output logic                      avm_chipselect,
    output logic                      avm_write_n,
    output logic [AVM_DATA_W-1:0]     avm_writedata,
    input  logic [AVM_DATA_W-1:0]     avm_readdata,
    output logic                      busy,
    output logic [DATA_W-1:0]         shadow,
    output logic                      err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [DATA_W-1:0] SHADOW_RST = RESET_VAL[DATA_W-1:0];

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  grant;
    logic [DATA_W-1:0]   data_terms [NUM_REQ];
    logic [PTR_W-1:0]    idx_terms  [NUM_REQ];
    logic [DATA_W-1:0]   data_sel;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    ptr_nxt;
    logic                unused_readdata;

    // Upper readdata bits are never compared; without readback none are.
    assign unused_readdata = ^avm_readdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // Mask each requester's slice and index by its grant bit so a simple OR
    // reduction yields the winner's data and index.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
        assign data_terms[gi] = grant[gi] ? req_data[gi*DATA_W +: DATA_W] : '0;
        assign idx_terms[gi]  = grant[gi] ? PTR_W'(gi) : '0;
    end

    // OR-reduce the masked terms and advance the pointer past the winner.
    always_comb begin
        data_sel  = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            data_sel  = data_sel | data_terms[i];
            grant_idx = grant_idx | idx_terms[i];
        end
        ptr_nxt = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end

    // Next-state logic: grant in IDLE, one bus cycle per phase, ack in DONE.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        shadow_d = shadow_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    grant_d = grant;
                    data_d  = data_sel;
                    ptr_d   = ptr_nxt;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                shadow_d = data_q;
`ifdef PIO_WRITE_ARBITER_READBACK_EN
                state_d  = ST_READ;
`else
                state_d  = ST_DONE;
`endif
            end
            ST_READ: begin
`ifdef PIO_WRITE_ARBITER_READBACK_EN
                if (avm_readdata[DATA_W-1:0] != data_q) begin
                    err_d = 1'b1;
                end
`endif
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset forces IDLE from any state, even mid-write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            shadow_q <= SHADOW_RST;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    // Bus and handshake outputs decode only registered state, never req.
    always_comb begin
        avm_address    = PIO_ADDR;
        avm_chipselect = (state_q == ST_WRITE) || (state_q == ST_READ);
        avm_write_n    = (state_q != ST_WRITE);
        avm_writedata  = '0;
        if (state_q == ST_WRITE) begin
            avm_writedata[DATA_W-1:0] = data_q;
        end
        ack    = (state_q == ST_DONE) ? grant_q : '0;
        busy   = (state_q != ST_IDLE);
        shadow = shadow_q;
        err    = err_q;
    end

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Scoreboard bench for pio_write_arbiter: the driver queues expected writes
// and acks, a negedge monitor pops and compares them as the DUT emits them.
module tb_pio_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 9;
`ifdef PIO_WRITE_ARBITER_READBACK_EN
    localparam int ACK_NEG = 4;   // negedges from req drive to ack
    localparam int PER     = 4;
`else
    localparam int ACK_NEG = 3;
    localparam int PER     = 3;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NR-1:0]  req = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]  ack;
    logic [1:0]     avm_address;
    logic           avm_chipselect;
    logic           avm_write_n;
    logic [31:0]    avm_writedata;
    logic [31:0]    avm_readdata;
    logic           busy;
    logic [DW-1:0]  shadow;
    logic           err;

    logic [31:0]    pio_q;
    logic           rd_zero = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_wd [$];
    logic [NR-1:0] exp_ack [$];

    pio_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .RESET_VAL(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_data       (req_data),
        .ack            (ack),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .busy           (busy),
        .shadow         (shadow),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Zero-wait PIO register model.
    assign avm_readdata = rd_zero ? 32'd0 : pio_q;
    always @(posedge clk) begin
        if (reset) pio_q <= 32'd4;
        else if (avm_chipselect && !avm_write_n) pio_q <= avm_writedata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write and every ack must match the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (avm_chipselect && !avm_write_n) begin
                if (exp_wd.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: got %h expected none", avm_writedata);
                end else begin
                    logic [31:0] e;
                    e = exp_wd.pop_front();
                    $display("write  addr=%0d data=%h exp=%h", avm_address, avm_writedata, e);
                    check("writedata", avm_writedata, e);
                    check("address", {30'd0, avm_address}, 32'd0);
                end
            end
            if (ack != '0) begin
                if (exp_ack.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_ack: got %b expected none", ack);
                end else begin
                    logic [NR-1:0] ea;
                    ea = exp_ack.pop_front();
                    $display("ack    got=%b exp=%b", ack, ea);
                    check("ack", {28'd0, ack}, {28'd0, ea});
                end
            end
        end
    end

    task automatic set_data(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic expect_txn(input int i, input logic [DW-1:0] v);
        exp_wd.push_back({23'd0, v});
        exp_ack.push_back(NR'(1) << i);
    endtask

    // Requester model: raise the given reqs, drop each one after its ack.
    task automatic run(input logic [NR-1:0] r, input int budget, output int first_ack, output int last_ack);
        int cnt;
        logic [NR-1:0] a;
        cnt = 0;
        first_ack = -1;
        last_ack = -1;
        req = r;
        while (req != '0 && cnt < budget) begin
            @(negedge clk);
            cnt++;
            a = ack;
            if (a != '0) begin
                if (first_ack < 0) first_ack = cnt;
                last_ack = cnt;
            end
            @(posedge clk); #1;
            req = req & ~a;
        end
        if (req != '0) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: req still %b after %0d cycles", req, cnt);
            req = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int f, l;
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_shadow", {23'd0, shadow}, 32'd4);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_cs", {31'd0, avm_chipselect}, 32'd0);
        check("rst_write_n", {31'd0, avm_write_n}, 32'd1);
        check("rst_ack", {28'd0, ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wdata", avm_writedata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_cs", {31'd0, avm_chipselect}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Single request on requester 2.
        set_data(2, 9'h1A5);
        expect_txn(2, 9'h1A5);
        run(4'b0100, 20, f, l);
        check("latency", f, ACK_NEG);
        check("shadow_1a5", {23'd0, shadow}, 32'h1A5);

        // All four requesting at once from a fresh pointer.
        do_reset();
        set_data(0, 9'h011); set_data(1, 9'h122);
        set_data(2, 9'h033); set_data(3, 9'h1C4);
        expect_txn(0, 9'h011); expect_txn(1, 9'h122);
        expect_txn(2, 9'h033); expect_txn(3, 9'h1C4);
        run(4'b1111, 40, f, l);
        check("rr_first_ack", f, ACK_NEG);
        check("rr_last_ack", l, ACK_NEG + 3 * PER);
        check("shadow_1c4", {23'd0, shadow}, 32'h1C4);

        // Readback mismatch; err is sticky until reset.
        set_data(0, 9'h0FF);
        expect_txn(0, 9'h0FF);
        rd_zero = 1'b1;
        run(4'b0001, 20, f, l);
        rd_zero = 1'b0;
`ifdef PIO_WRITE_ARBITER_READBACK_EN
        check("err_set", {31'd0, err}, 32'd1);
`else
        check("err_tied", {31'd0, err}, 32'd0);
`endif
        set_data(1, 9'h055);
        expect_txn(1, 9'h055);
        run(4'b0010, 20, f, l);
`ifdef PIO_WRITE_ARBITER_READBACK_EN
        check("err_sticky", {31'd0, err}, 32'd1);
`else
        check("err_tied2", {31'd0, err}, 32'd0);
`endif
        do_reset();
        check("err_cleared", {31'd0, err}, 32'd0);

        // Reset asserted in the WRITE cycle aborts without ack.
        set_data(1, 9'h0AA);
        req = 4'b0010;
        @(posedge clk); #1;
        check("mid_busy", {31'd0, busy}, 32'd1);
        check("mid_cs", {31'd0, avm_chipselect}, 32'd1);
        reset = 1'b1;
        req = '0;
        @(posedge clk); #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ack", {28'd0, ack}, 32'd0);
        check("abort_shadow", {23'd0, shadow}, 32'd4);
        check("abort_cs", {31'd0, avm_chipselect}, 32'd0);
        reset = 1'b0;
        // Pointer must be back at 0: requester 1 wins before 3.
        set_data(1, 9'h066); set_data(3, 9'h077);
        expect_txn(1, 9'h066); expect_txn(3, 9'h077);
        run(4'b1010, 40, f, l);
        check("shadow_077", {23'd0, shadow}, 32'h077);

        repeat (3) @(posedge clk);
        check("queues_empty", exp_wd.size() + exp_ack.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
